// File: rtl/fa32_sched.sv
// rtl/fa32_sched.sv - round-robin scheduler sharing one combinational fa32_int adder
// Narrow ops take one adder beat; wide ops chain lo then hi with the lo carry.
module fa32_sched #(
  parameter int NREQ = 2,
  parameter int RRP0 = 0
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_wide,
  input  logic [NREQ-1:0]   req_ci,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [63:0]       rsp_sum,
  output logic              rsp_co32,
  output logic              rsp_co31,
  output logic              rsp_co24,
  output logic              rsp_ovf,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_c,
  input  logic [31:0]       add_s,
  input  logic              add_co32,
  input  logic              add_co31,
  input  logic              add_co24
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [IW-1:0] RR_RESET = IW'((RRP0 + NREQ - 1) % NREQ);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RSP} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr, id, winner;
  logic            found;
  logic [63:0]     sel_a, sel_b, a_q, b_q, sum_q;
  logic            sel_wide, sel_ci, wide_q, ci_q, cy;
  logic            co32_q, co31_q, co24_q;

  // Round-robin search begins one past the last winner.
  always_comb begin
    int idx_i;
    logic [IW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx_i  = 0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_i = (int'(rr) + k) % NREQ;
      idx   = IW'(idx_i);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_wide = 1'b0;
    sel_ci   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) begin
        sel_a    = req_a[i*64 +: 64];
        sel_b    = req_b[i*64 +: 64];
        sel_wide = req_wide[i];
        sel_ci   = req_ci[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (found) state_nx = S_LO;
      S_LO:    state_nx = wide_q ? S_HI : S_RSP;
      S_HI:    state_nx = S_RSP;
      S_RSP:   if (rsp_ready[id]) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    add_a     = '0;
    add_b     = '0;
    add_c     = 1'b0;
    case (state)
      S_IDLE: if (found) req_ready[winner] = 1'b1;
      S_LO: begin
        add_a = a_q[31:0];
        add_b = b_q[31:0];
        add_c = ci_q;
      end
      S_HI: begin
        add_a = a_q[63:32];
        add_b = b_q[63:32];
        add_c = cy;
      end
      S_RSP:   rsp_valid[id] = 1'b1;
      default: ;
    endcase
  end

  // Sum and flags are captured in the same edge the adder is driven.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      rr     <= RR_RESET;
      id     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      wide_q <= 1'b0;
      ci_q   <= 1'b0;
      cy     <= 1'b0;
      sum_q  <= '0;
      co32_q <= 1'b0;
      co31_q <= 1'b0;
      co24_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          rr     <= winner;
          id     <= winner;
          a_q    <= sel_a;
          b_q    <= sel_b;
          wide_q <= sel_wide;
          ci_q   <= sel_ci;
        end
        S_LO: begin
          sum_q[31:0] <= add_s;
          cy          <= add_co32;
          if (!wide_q) begin
            sum_q[63:32] <= '0;
            co32_q       <= add_co32;
            co31_q       <= add_co31;
            co24_q       <= add_co24;
          end
        end
        S_HI: begin
          sum_q[63:32] <= add_s;
          co32_q       <= add_co32;
          co31_q       <= add_co31;
          co24_q       <= add_co24;
        end
        default: ;
      endcase
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_co32 = co32_q;
  assign rsp_co31 = co31_q;
  assign rsp_co24 = co24_q;
  assign rsp_ovf  = co32_q ^ co31_q;

endmodule

// File: tb/tb_fa32_sched.sv
// tb/tb_fa32_sched.sv - randomized bench for fa32_sched against a 64-bit arithmetic model
module tb_fa32_sched;
  localparam int NREQ = 2;
  localparam int RRP0 = 0;

  logic              clk = 1'b0;
  logic              resetl;
  logic [NREQ-1:0]   req_valid, req_ready, req_wide, req_ci, rsp_valid, rsp_ready;
  logic [NREQ*64-1:0] req_a, req_b;
  logic [63:0]       rsp_sum;
  logic              rsp_co32, rsp_co31, rsp_co24, rsp_ovf;
  logic [31:0]       add_a, add_b, add_s;
  logic              add_c, add_co32, add_co31, add_co24;

  int tests = 0;
  int fails = 0;
  int rr_m;
  logic [63:0] ta [NREQ];
  logic [63:0] tb_ [NREQ];
  logic        tw [NREQ];
  logic        tci [NREQ];

  fa32_sched #(.NREQ(NREQ), .RRP0(RRP0)) dut (
    .clk(clk), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide), .req_ci(req_ci),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_co32(rsp_co32), .rsp_co31(rsp_co31), .rsp_co24(rsp_co24), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .add_s(add_s), .add_co32(add_co32), .add_co31(add_co31), .add_co24(add_co24)
  );

  always #5 clk = ~clk;

  // External combinational adder.
  logic [32:0] ad33;
  logic [31:0] ad31;
  logic [24:0] ad24;
  assign ad33 = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_c};
  assign ad31 = {1'b0, add_a[30:0]} + {1'b0, add_b[30:0]} + {31'b0, add_c};
  assign ad24 = {1'b0, add_a[23:0]} + {1'b0, add_b[23:0]} + {24'b0, add_c};
  assign add_s    = ad33[31:0];
  assign add_co32 = ad33[32];
  assign add_co31 = ad31[31];
  assign add_co24 = ad24[24];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Whole-width reference: flags come from the top word of the full add.
  task automatic ref_op(input logic w, input logic ci, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] s, output logic c32, output logic c31, output logic c24);
    logic [64:0] f;
    logic [63:0] f63;
    logic [56:0] f56;
    logic [32:0] n;
    logic [31:0] n31;
    logic [24:0] n24;
    if (w) begin
      f   = {1'b0, a} + {1'b0, b} + 65'(ci);
      f63 = {1'b0, a[62:0]} + {1'b0, b[62:0]} + 64'(ci);
      f56 = {1'b0, a[55:0]} + {1'b0, b[55:0]} + 57'(ci);
      s = f[63:0]; c32 = f[64]; c31 = f63[63]; c24 = f56[56];
    end else begin
      n   = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(ci);
      n31 = {1'b0, a[30:0]} + {1'b0, b[30:0]} + 32'(ci);
      n24 = {1'b0, a[23:0]} + {1'b0, b[23:0]} + 25'(ci);
      s = {32'b0, n[31:0]}; c32 = n[32]; c31 = n31[31]; c24 = n24[24];
    end
  endtask

  task automatic drive_reqs(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*64 +: 64] = ta[i];
      req_b[i*64 +: 64] = tb_[i];
      req_wide[i]       = tw[i];
      req_ci[i]         = tci[i];
    end
    req_valid = mask;
  endtask

  function automatic int pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic do_op(input logic [NREQ-1:0] mask, input int hold);
    int w, lat;
    logic [63:0] es, lo33;
    logic e32, e31, e24;
    w = pick(mask);
    drive_reqs(mask);
    #1;
    check("grant", req_ready, 64'(1) << w);
    tick;
    req_valid = '0;
    rr_m = w;
    ref_op(tw[w], tci[w], ta[w], tb_[w], es, e32, e31, e24);
    lo33 = {31'b0, ta[w][31:0]} + {31'b0, tb_[w][31:0]} + 64'(tci[w]);
    check("lo_add_a", add_a, ta[w][31:0]);
    check("lo_add_c", add_c, tci[w]);
    lat = 0;
    while (rsp_valid == '0 && lat < 8) begin
      if (lat == 1 && tw[w]) begin
        check("hi_add_a", add_a, ta[w][63:32]);
        check("hi_add_c", add_c, lo33[32]);
      end
      tick;
      lat++;
    end
    check("latency", lat, tw[w] ? 2 : 1);
    check("rsp_valid", rsp_valid, 64'(1) << w);
    check("rsp_sum", rsp_sum, es);
    check("rsp_flags", {rsp_co32, rsp_co31, rsp_co24, rsp_ovf}, {e32, e31, e24, e32 ^ e31});
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~(NREQ'(1) << w);
      req_valid = NREQ'($urandom);
      tick;
      check("hold_valid", rsp_valid, 64'(1) << w);
      check("hold_sum", rsp_sum, es);
      check("hold_flags", {rsp_co32, rsp_co31, rsp_co24}, {e32, e31, e24});
      check("hold_ready", req_ready, 0);
      check("hold_add", {add_a, add_b, add_c}, 0);
    end
    req_valid = '0;
    rsp_ready = NREQ'(1) << w;
    tick;
    rsp_ready = '0;
    check("rsp_done", rsp_valid, 0);
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < NREQ; i++) begin
      ta[i]  = {$urandom, $urandom};
      tb_[i] = {$urandom, $urandom};
      tw[i]  = 1'($urandom);
      tci[i] = 1'($urandom);
    end
  endtask

  initial begin
    resetl = 1'b0; req_valid = '0; rsp_ready = '0; req_wide = '0; req_ci = '0;
    req_a = '0; req_b = '0;
    rr_m = (RRP0 + NREQ - 1) % NREQ;
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tb_[i] = '0; tw[i] = 1'b0; tci[i] = 1'b0; end
    tick; tick;
    check("reset_out", {req_ready, rsp_valid, rsp_sum, rsp_co32, rsp_co31, rsp_co24, rsp_ovf}, 0);
    check("reset_add", {add_a, add_b, add_c}, 0);
    resetl = 1'b1;
    tick;

    ta[0] = 64'hFFFFFFFF; tb_[0] = 64'h1; tw[0] = 1'b0; tci[0] = 1'b0;
    do_op(2'b01, 0);
    ta[1] = 64'h00000000_FFFFFFFF; tb_[1] = 64'h1; tw[1] = 1'b1; tci[1] = 1'b0;
    do_op(2'b10, 0);
    ta[0] = 64'h7FFFFFFF; tb_[0] = 64'h1; tw[0] = 1'b0;
    do_op(2'b01, 0);
    ta[1] = 64'h00FFFFFF; tb_[1] = 64'h1; tw[1] = 1'b0;
    do_op(2'b10, 10);

    for (int n = 0; n < 40; n++) begin
      rand_ops(1);
      do_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3));
    end

    // Reset asserted while the hi beat of a wide op is on the adder.
    ta[1] = {$urandom, $urandom}; tb_[1] = {$urandom, $urandom}; tw[1] = 1'b1; tci[1] = 1'b1;
    drive_reqs(2'b10);
    tick;
    req_valid = '0;
    tick;
    check("pre_reset_hi", add_a, ta[1][63:32]);
    resetl = 1'b0;
    #1;
    check("async_reset_out", {req_ready, rsp_valid, rsp_sum, rsp_co32, rsp_co31, rsp_co24, rsp_ovf}, 0);
    check("async_reset_add", {add_a, add_b, add_c}, 0);
    tick;
    resetl = 1'b1;
    rr_m = (RRP0 + NREQ - 1) % NREQ;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("no_stale_rsp", rsp_valid, 0);
    end

    for (int n = 0; n < 10; n++) begin
      rand_ops(1);
      do_op(2'b11, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
